// File: rtl/id_stage_pipe.sv
// Instruction-decode stage: field decode, condition check, register-file read with
// optional write-back forwarding, and a handshaked ID/EX pipeline register.
module id_stage_pipe #(
  parameter int unsigned N        = 32,
  parameter int unsigned NUM_REGS = 16,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instruction_in,
  input  logic [N-1:0]  pc_in,
  input  logic [3:0]    status_in,
  input  logic          hazard_in,
  input  logic          flush_in,
  input  logic          wb_enable_in,
  input  logic [3:0]    wb_dest_in,
  input  logic [N-1:0]  wb_value_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  pc_out,
  output logic [N-1:0]  val_rn_out,
  output logic [N-1:0]  val_rm_out,
  output logic [3:0]    exe_cmd_out,
  output logic          s_out,
  output logic          b_out,
  output logic          i_out,
  output logic          mem_read_enable_out,
  output logic          mem_write_enable_out,
  output logic          wb_enable_out,
  output logic          two_src_out,
  output logic [3:0]    dest_out,
  output logic [3:0]    src1_out,
  output logic [3:0]    src2_out,
  output logic [11:0]   shift_operand_out,
  output logic [23:0]   imm24_out
);

  logic [3:0] cond, opcode, rn, rd, rm, src2;
  logic [1:0] mode;
  logic       imm_bit, s_bit, is_str;
  logic       flag_n, flag_z, flag_c, flag_v;

  assign cond    = instruction_in[31:28];
  assign mode    = instruction_in[27:26];
  assign imm_bit = instruction_in[25];
  assign opcode  = instruction_in[24:21];
  assign s_bit   = instruction_in[20];
  assign rn      = instruction_in[19:16];
  assign rd      = instruction_in[15:12];
  assign rm      = instruction_in[3:0];
  assign {flag_n, flag_z, flag_c, flag_v} = status_in;
  assign is_str  = (mode == 2'b01) && !s_bit;
  assign src2    = is_str ? rd : rm;

  logic advance, accept;
  assign advance  = !out_valid || out_ready;
  assign in_ready = rst && advance && !hazard_in && !flush_in;
  assign accept   = in_valid && in_ready;

  // Condition-field evaluation against incoming flags
  logic cond_pass;
  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  // Control decode; a failed condition squashes every control bit
  logic [3:0] d_exe;
  logic       d_s, d_b, d_i, d_mem_rd, d_mem_wr, d_wb, d_two_src, d_known;
  always_comb begin
    d_exe     = 4'b0000;
    d_s       = 1'b0;
    d_b       = 1'b0;
    d_i       = 1'b0;
    d_mem_rd  = 1'b0;
    d_mem_wr  = 1'b0;
    d_wb      = 1'b0;
    d_two_src = 1'b0;
    d_known   = 1'b1;
    case (mode)
      2'b00: begin
        case (opcode)
          4'b1101: begin d_exe = 4'b0001; d_wb = 1'b1; end
          4'b1111: begin d_exe = 4'b1001; d_wb = 1'b1; end
          4'b0100: begin d_exe = 4'b0010; d_wb = 1'b1; end
          4'b0101: begin d_exe = 4'b0011; d_wb = 1'b1; end
          4'b0010: begin d_exe = 4'b0100; d_wb = 1'b1; end
          4'b0110: begin d_exe = 4'b0101; d_wb = 1'b1; end
          4'b0000: begin d_exe = 4'b0110; d_wb = 1'b1; end
          4'b1100: begin d_exe = 4'b0111; d_wb = 1'b1; end
          4'b0001: begin d_exe = 4'b1000; d_wb = 1'b1; end
          4'b1010: d_exe = 4'b0100;
          4'b1000: d_exe = 4'b0110;
          default: d_known = 1'b0;
        endcase
        if (d_known) begin
          d_s       = s_bit;
          d_i       = imm_bit;
          d_two_src = !imm_bit;
        end
      end
      2'b01: begin
        d_exe     = 4'b0010;
        d_i       = imm_bit;
        d_mem_rd  = s_bit;
        d_wb      = s_bit;
        d_mem_wr  = !s_bit;
        d_two_src = !imm_bit || is_str;
      end
      2'b10: d_b = 1'b1;
      default: ;
    endcase
    if (!cond_pass) begin
      d_exe     = 4'b0000;
      d_s       = 1'b0;
      d_b       = 1'b0;
      d_i       = 1'b0;
      d_mem_rd  = 1'b0;
      d_mem_wr  = 1'b0;
      d_wb      = 1'b0;
      d_two_src = 1'b0;
    end
  end

  logic [N-1:0] regs [NUM_REGS];

  // Register file; writes to unimplemented indices fall through the loop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_enable_in) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wb_dest_in == 4'(i)) regs[i] <= wb_value_in;
      end
    end
  end

  // Operand read with optional same-cycle forwarding of the write-back port
  logic [N-1:0] rn_val, rm_val;
  always_comb begin
    rn_val = '0;
    rm_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rn == 4'(i))   rn_val = regs[i];
      if (src2 == 4'(i)) rm_val = regs[i];
    end
    if (BYPASS && wb_enable_in) begin
      if (rn == wb_dest_in && 32'(rn) < NUM_REGS)     rn_val = wb_value_in;
      if (src2 == wb_dest_in && 32'(src2) < NUM_REGS) rm_val = wb_value_in;
    end
    if (mode == 2'b10) begin
      rn_val = '0;
      rm_val = '0;
    end
  end

  // ID/EX register: flush or an idle advance loads a bubble, a stall holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid            <= 1'b0;
      pc_out               <= '0;
      val_rn_out           <= '0;
      val_rm_out           <= '0;
      exe_cmd_out          <= 4'b0000;
      s_out                <= 1'b0;
      b_out                <= 1'b0;
      i_out                <= 1'b0;
      mem_read_enable_out  <= 1'b0;
      mem_write_enable_out <= 1'b0;
      wb_enable_out        <= 1'b0;
      two_src_out          <= 1'b0;
      dest_out             <= 4'b0000;
      src1_out             <= 4'b0000;
      src2_out             <= 4'b0000;
      shift_operand_out    <= 12'h000;
      imm24_out            <= 24'h000000;
    end else if (flush_in || (advance && !accept)) begin
      out_valid            <= 1'b0;
      pc_out               <= '0;
      val_rn_out           <= '0;
      val_rm_out           <= '0;
      exe_cmd_out          <= 4'b0000;
      s_out                <= 1'b0;
      b_out                <= 1'b0;
      i_out                <= 1'b0;
      mem_read_enable_out  <= 1'b0;
      mem_write_enable_out <= 1'b0;
      wb_enable_out        <= 1'b0;
      two_src_out          <= 1'b0;
      dest_out             <= 4'b0000;
      src1_out             <= 4'b0000;
      src2_out             <= 4'b0000;
      shift_operand_out    <= 12'h000;
      imm24_out            <= 24'h000000;
    end else if (accept) begin
      out_valid            <= 1'b1;
      pc_out               <= pc_in;
      val_rn_out           <= rn_val;
      val_rm_out           <= rm_val;
      exe_cmd_out          <= d_exe;
      s_out                <= d_s;
      b_out                <= d_b;
      i_out                <= d_i;
      mem_read_enable_out  <= d_mem_rd;
      mem_write_enable_out <= d_mem_wr;
      wb_enable_out        <= d_wb;
      two_src_out          <= d_two_src;
      dest_out             <= rd;
      src1_out             <= rn;
      src2_out             <= src2;
      shift_operand_out    <= instruction_in[11:0];
      imm24_out            <= instruction_in[23:0];
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe: forwarding and non-forwarding instances share stimulus.
module tb_id_stage_pipe;

  logic        clk, rst;
  logic        in_valid, hazard_in, flush_in, wb_enable_in, out_ready;
  logic [31:0] instruction_in, pc_in, wb_value_in;
  logic [3:0]  status_in, wb_dest_in;

  logic        in_ready, out_valid, s_out, b_out, i_out, mem_rd, mem_wr, wb_out, two_src;
  logic [31:0] pc_out, val_rn, val_rm;
  logic [3:0]  exe_cmd, dest_out, src1_out, src2_out;
  logic [11:0] shift_op;
  logic [23:0] imm24;

  logic        b0_in_ready, b0_out_valid, b0_s, b0_b, b0_i, b0_mem_rd, b0_mem_wr, b0_wb, b0_two_src;
  logic [31:0] b0_pc, b0_val_rn, b0_val_rm;
  logic [3:0]  b0_exe, b0_dest, b0_src1, b0_src2;
  logic [11:0] b0_shift;
  logic [23:0] b0_imm24;

  int passed = 0;
  int total  = 0;

  id_stage_pipe #(.N(32), .NUM_REGS(16), .BYPASS(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .instruction_in(instruction_in), .pc_in(pc_in), .status_in(status_in),
    .hazard_in(hazard_in), .flush_in(flush_in), .wb_enable_in(wb_enable_in),
    .wb_dest_in(wb_dest_in), .wb_value_in(wb_value_in), .out_valid(out_valid),
    .out_ready(out_ready), .pc_out(pc_out), .val_rn_out(val_rn), .val_rm_out(val_rm),
    .exe_cmd_out(exe_cmd), .s_out(s_out), .b_out(b_out), .i_out(i_out),
    .mem_read_enable_out(mem_rd), .mem_write_enable_out(mem_wr), .wb_enable_out(wb_out),
    .two_src_out(two_src), .dest_out(dest_out), .src1_out(src1_out), .src2_out(src2_out),
    .shift_operand_out(shift_op), .imm24_out(imm24)
  );

  id_stage_pipe #(.N(32), .NUM_REGS(16), .BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b0_in_ready),
    .instruction_in(instruction_in), .pc_in(pc_in), .status_in(status_in),
    .hazard_in(hazard_in), .flush_in(flush_in), .wb_enable_in(wb_enable_in),
    .wb_dest_in(wb_dest_in), .wb_value_in(wb_value_in), .out_valid(b0_out_valid),
    .out_ready(out_ready), .pc_out(b0_pc), .val_rn_out(b0_val_rn), .val_rm_out(b0_val_rm),
    .exe_cmd_out(b0_exe), .s_out(b0_s), .b_out(b0_b), .i_out(b0_i),
    .mem_read_enable_out(b0_mem_rd), .mem_write_enable_out(b0_mem_wr), .wb_enable_out(b0_wb),
    .two_src_out(b0_two_src), .dest_out(b0_dest), .src1_out(b0_src1), .src2_out(b0_src2),
    .shift_operand_out(b0_shift), .imm24_out(b0_imm24)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [3:0] idx, input logic [31:0] val);
    wb_enable_in = 1'b1; wb_dest_in = idx; wb_value_in = val;
    tick();
    wb_enable_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; hazard_in = 1'b0; flush_in = 1'b0;
    wb_enable_in = 1'b0; wb_dest_in = 4'd0; wb_value_in = 32'd0;
    instruction_in = 32'hE0821003; pc_in = 32'h10; status_in = 4'b0000;
    #2 rst = 1'b0;
    #6;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", in_ready); else passed++;
    total++; if (exe_cmd !== 4'd0) $display("FAIL reset_exe got %h exp 0", exe_cmd); else passed++;
    total++; if (pc_out !== 32'd0) $display("FAIL reset_pc got %h exp 0", pc_out); else passed++;
    total++; if (wb_out !== 1'b0) $display("FAIL reset_wb got %b exp 0", wb_out); else passed++;
    total++; if (val_rn !== 32'd0) $display("FAIL reset_val_rn got %h exp 0", val_rn); else passed++;
    in_valid = 1'b0;
    #4 rst = 1'b1;
    tick();
  endtask

  task automatic test_add();
    write_reg(4'd2, 32'd5);
    write_reg(4'd3, 32'd7);
    in_valid = 1'b1; instruction_in = 32'hE0821003; pc_in = 32'h40;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL add_valid got %b exp 1", out_valid); else passed++;
    total++; if (exe_cmd !== 4'b0010) $display("FAIL add_exe got %h exp 2", exe_cmd); else passed++;
    total++; if (val_rn !== 32'd5) $display("FAIL add_val_rn got %h exp 5", val_rn); else passed++;
    total++; if (val_rm !== 32'd7) $display("FAIL add_val_rm got %h exp 7", val_rm); else passed++;
    total++; if (dest_out !== 4'd1) $display("FAIL add_dest got %h exp 1", dest_out); else passed++;
    total++; if (wb_out !== 1'b1) $display("FAIL add_wb got %b exp 1", wb_out); else passed++;
    total++; if (two_src !== 1'b1) $display("FAIL add_two_src got %b exp 1", two_src); else passed++;
    total++; if (pc_out !== 32'h40) $display("FAIL add_pc got %h exp 40", pc_out); else passed++;
  endtask

  task automatic test_bypass();
    in_valid = 1'b1; instruction_in = 32'hE0821003; pc_in = 32'h44;
    wb_enable_in = 1'b1; wb_dest_in = 4'd2; wb_value_in = 32'h55;
    tick();
    wb_enable_in = 1'b0; in_valid = 1'b0;
    total++; if (val_rn !== 32'h55) $display("FAIL bypass_on got %h exp 55", val_rn); else passed++;
    total++; if (b0_val_rn !== 32'd5) $display("FAIL bypass_off got %h exp 5", b0_val_rn); else passed++;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    total++; if (b0_val_rn !== 32'h55) $display("FAIL bypass_off_next got %h exp 55", b0_val_rn); else passed++;
  endtask

  task automatic test_cond();
    in_valid = 1'b1; instruction_in = 32'h01A04003; pc_in = 32'h50; status_in = 4'b0000;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL moveq_fail_valid got %b exp 1", out_valid); else passed++;
    total++; if (exe_cmd !== 4'd0) $display("FAIL moveq_fail_exe got %h exp 0", exe_cmd); else passed++;
    total++; if (wb_out !== 1'b0) $display("FAIL moveq_fail_wb got %b exp 0", wb_out); else passed++;
    status_in = 4'b0100; pc_in = 32'h54;
    tick();
    in_valid = 1'b0; status_in = 4'b0000;
    total++; if (exe_cmd !== 4'b0001) $display("FAIL moveq_pass_exe got %h exp 1", exe_cmd); else passed++;
    total++; if (wb_out !== 1'b1) $display("FAIL moveq_pass_wb got %b exp 1", wb_out); else passed++;
    total++; if (val_rm !== 32'd7) $display("FAIL moveq_pass_rm got %h exp 7", val_rm); else passed++;
  endtask

  task automatic test_decode_modes();
    in_valid = 1'b1; instruction_in = 32'hE4916004;
    tick();
    total++; if ({exe_cmd, mem_rd, mem_wr, wb_out, two_src, s_out} !== {4'b0010, 5'b10110})
      $display("FAIL ldr_ctrl got %h/%b%b%b%b%b exp 2/10110", exe_cmd, mem_rd, mem_wr, wb_out, two_src, s_out); else passed++;
    total++; if (dest_out !== 4'd6) $display("FAIL ldr_dest got %h exp 6", dest_out); else passed++;
    instruction_in = 32'hE4816000;
    tick();
    total++; if ({mem_rd, mem_wr, wb_out, two_src} !== 4'b0101)
      $display("FAIL str_ctrl got %b%b%b%b exp 0101", mem_rd, mem_wr, wb_out, two_src); else passed++;
    total++; if (src2_out !== 4'd6) $display("FAIL str_src2 got %h exp 6", src2_out); else passed++;
    instruction_in = 32'hEA020010;
    tick();
    total++; if ({b_out, exe_cmd, wb_out} !== {1'b1, 4'd0, 1'b0})
      $display("FAIL branch_ctrl got %b/%h/%b exp 1/0/0", b_out, exe_cmd, wb_out); else passed++;
    total++; if (val_rn !== 32'd0) $display("FAIL branch_val_rn got %h exp 0", val_rn); else passed++;
    total++; if (imm24 !== 24'h020010) $display("FAIL branch_imm24 got %h exp 020010", imm24); else passed++;
    instruction_in = 32'hE3510005;
    tick();
    in_valid = 1'b0;
    total++; if ({exe_cmd, s_out, i_out, wb_out, two_src} !== {4'b0100, 4'b1100})
      $display("FAIL cmp_ctrl got %h/%b%b%b%b exp 4/1100", exe_cmd, s_out, i_out, wb_out, two_src); else passed++;
    total++; if (shift_op !== 12'h005) $display("FAIL cmp_shift got %h exp 005", shift_op); else passed++;
  endtask

  task automatic test_back_to_back();
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL stall_empty got %b exp 0", out_valid); else passed++;
    out_ready = 1'b0; in_valid = 1'b1; instruction_in = 32'hE0821003; pc_in = 32'h100;
    tick();
    total++; if (pc_out !== 32'h100) $display("FAIL stall_first_pc got %h exp 100", pc_out); else passed++;
    instruction_in = 32'hE0415002; pc_in = 32'h104;
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (in_ready !== 1'b0) $display("FAIL stall_in_ready%0d got %b exp 0", k, in_ready); else passed++;
      tick();
      total++; if (pc_out !== 32'h100 || out_valid !== 1'b1)
        $display("FAIL stall_hold%0d got %h/%b exp 100/1", k, pc_out, out_valid); else passed++;
    end
    out_ready = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) $display("FAIL stall_release got %b exp 1", in_ready); else passed++;
    tick();
    in_valid = 1'b0;
    total++; if (pc_out !== 32'h104 || exe_cmd !== 4'b0100 || dest_out !== 4'd5)
      $display("FAIL stall_second got %h/%h/%h exp 104/4/5", pc_out, exe_cmd, dest_out); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL stall_drain got %b exp 0", out_valid); else passed++;
  endtask

  task automatic test_hazard();
    in_valid = 1'b1; instruction_in = 32'hE0821003; pc_in = 32'h200; hazard_in = 1'b1;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL hazard_in_ready got %b exp 0", in_ready); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL hazard_bubble got %b exp 0", out_valid); else passed++;
    hazard_in = 1'b0;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1 || pc_out !== 32'h200)
      $display("FAIL hazard_accept got %b/%h exp 1/200", out_valid, pc_out); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; flush_in = 1'b1; in_valid = 1'b1; pc_in = 32'h300;
    #1;
    total++; if (in_ready !== 1'b0) $display("FAIL flush_in_ready got %b exp 0", in_ready); else passed++;
    tick();
    flush_in = 1'b0; in_valid = 1'b0;
    total++; if (out_valid !== 1'b0 || wb_out !== 1'b0 || exe_cmd !== 4'd0)
      $display("FAIL flush_clear got %b/%b/%h exp 0/0/0", out_valid, wb_out, exe_cmd); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL flush_not_taken got %b exp 0", out_valid); else passed++;
    out_ready = 1'b1;
  endtask

  task automatic test_mid_reset();
    in_valid = 1'b1; pc_in = 32'h400;
    tick();
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL midrst_live got %b exp 1", out_valid); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || pc_out !== 32'd0)
      $display("FAIL midrst_drop got %b/%h exp 0/0", out_valid, pc_out); else passed++;
    #3 rst = 1'b1;
  endtask

  initial begin
    test_reset();
    test_add();
    test_bypass();
    test_cond();
    test_decode_modes();
    test_back_to_back();
    test_hazard();
    test_flush();
    test_mid_reset();
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/id_stage_pipe.md
# id_stage_pipe

Parametrised, registered instruction-decode stage for the ARM-subset pipeline. Decodes one 32-bit instruction per cycle, reads operands from an internal register file of configurable width and depth, and checks the condition field against the incoming status flags. Results land in an internal ID/EX pipeline register with a valid/ready handshake on both sides, plus stall, flush and write-back bypass. Sits between the fetch stage and the execute stage.

## Interface
- N, 32, data/register width
- NUM_REGS, 16, implemented registers (1..16); reads of unimplemented indices return 0, writes to them are dropped
- BYPASS, 1, 1 = same-cycle write-back forwarding into operand reads; 0 = no forwarding
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- in_valid  in  1  fetch offers instruction_in/pc_in
- in_ready  out  1  stage accepts this cycle
- instruction_in  in  32  instruction word
- pc_in  in  N  PC of the instruction
- status_in  in  4  {N,Z,C,V} flags
- hazard_in  in  1  stall request from hazard unit
- flush_in  in  1  taken branch; discard in-flight decode
- wb_enable_in  in  1  register write strobe
- wb_dest_in  in  4  write index
- wb_value_in  in  N  write data
- out_valid  out  1  ID/EX register holds a live instruction
- out_ready  in  1  execute consumes
- pc_out, val_rn_out, val_rm_out  out  N  registered PC and operands
- exe_cmd_out  out  4  ALU command
- s_out, b_out, i_out, mem_read_enable_out, mem_write_enable_out, wb_enable_out, two_src_out  out  1 each  registered controls
- dest_out, src1_out, src2_out  out  4  registered register indices
- shift_operand_out  out  12  instruction[11:0]
- imm24_out  out  24  instruction[23:0]

## Operation
- Fields: cond[31:28], mode[27:26], I[25], opcode[24:21], S[20], Rn[19:16], Rd[15:12], Rm[3:0].
- Mode 00 (data): MOV 1101->0001, MVN 1111->1001, ADD 0100->0010, ADC 0101->0011, SUB 0010->0100, SBC 0110->0101, AND 0000->0110, ORR 1100->0111, EOR 0001->1000, CMP 1010->0100, TST 1000->0110. wb_enable=1 except CMP/TST. s=S. Other opcodes: all controls 0.
- Mode 01 (memory): exe_cmd 0010; S=1 LDR (mem_read, wb_enable); S=0 STR (mem_write). s=0.
- Mode 10 (branch): b=1, other controls 0. Mode 11: all controls 0.
- src2 = Rd for STR, else Rm. two_src = ~I | STR. Branch skips register reads (val_rn/val_rm registered as 0).
- Condition: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~C|Z, GE N==V, LT N!=V, GT ~Z&(N==V), LE Z|(N!=V), AL 1, 1111 0. Failed condition: instruction accepted, all control outputs registered 0, out_valid=1 (keeps PC order).
- Register file: NUM_REGS×N, written on rising edge when wb_enable_in. BYPASS=1: read of index == wb_dest_in with wb_enable_in returns wb_value_in.
- Handshake: advance = ~out_valid | out_ready. in_ready = advance & ~hazard_in & ~flush_in. Accept = in_valid & in_ready.
- On advance: accept -> load decoded instruction, out_valid=1; else load bubble (controls 0), out_valid=0.
- No advance: ID/EX register holds all fields.
- flush_in: ID/EX cleared to bubble next edge, out_valid=0, regardless of out_ready; overrides hazard_in and accept.

## Timing
- Decode latency 1 cycle: accepted at edge k, visible on outputs after edge k.
- Throughput 1 instruction/cycle with out_ready=1.
- Register write at edge k visible to a decode accepted at edge k+1 regardless of BYPASS; same edge only with BYPASS=1.
- Reset (rst=0): all outputs 0, out_valid=0, all registers 0; in_ready=0 while rst=0. Reset mid-operation drops the held instruction.
- hazard_in and out_ready=0 together: ID/EX holds, in_ready=0.

## Test plan
- Reset, then ADD R1,R2,R3 (0xE0821003) with R2=5, R3=7, out_ready=1 -> next cycle out_valid=1, exe_cmd 0010, val_rn 5, val_rm 7, dest 1, wb_enable 1.
- BYPASS=1: wb write R2=0x55 in same cycle ADD reads R2 -> val_rn 0x55; BYPASS=0 -> old value.
- MOVEQ with Z=0 -> out_valid=1, all controls 0; with Z=1 -> exe_cmd 0001, wb_enable 1.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; release -> both instructions delivered in order.
- hazard_in=1 one cycle -> bubble (out_valid=0), instruction held at input accepted next cycle.
- flush_in with live ID/EX and out_ready=0 -> out_valid=0 next cycle, input not accepted.
